// File: rtl/vga_timing_if.sv
// Raster-scan outputs of vga_timing_gen: pixel counters, tick/frame strobes and
// the delayed sync/blank pins. The master drives, draw stages and the DAC read.
interface vga_timing_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        pixelTick;
  logic        startOfFrame;
  logic        hsync;
  logic        vsync;
  logic        blankN;

  modport master (output pixelX, pixelY, pixelTick, startOfFrame, hsync, vsync, blankN);
  modport slave  (input  pixelX, pixelY, pixelTick, startOfFrame, hsync, vsync, blankN);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync/blank decode and a SYNC_DELAY-deep
// alignment delay line. Define VGA_CLK_DIV2_EN to advance pixels every 2nd clk.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);
  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL      = (SYNC_POL != 0);
  // Packed as {hsync, vsync, blankN}; idle value used for reset and empty stages.
  localparam logic [2:0]  INACT    = {~POL, ~POL, 1'b0};

  logic        r_tick;
  logic        r_sof;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_blank_n;
  logic [2:0]  w_dec;
  logic [2:0]  w_out;

`ifdef VGA_CLK_DIV2_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) r_tick <= 1'b0;
    else       r_tick <= ~r_tick;
`else
  always_ff @(posedge clk or posedge reset)
    if (reset) r_tick <= 1'b0;
    else       r_tick <= 1'b1;
`endif

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // startOfFrame is set by the same edge that wraps the counters to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sof <= 1'b0;
    end else begin
      r_sof <= r_tick && w_x_last && w_y_last;
      if (r_tick) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? 11'd0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign w_hs_act  = (r_x >= HS_START) && (r_x < HS_END);
  assign w_vs_act  = (r_y >= VS_START) && (r_y < VS_END);
  assign w_blank_n = (r_x < X_ACT) && (r_y < Y_ACT);
  // Forced idle while reset is held so a zero-depth line still shows reset values.
  assign w_dec = reset ? INACT
               : {(w_hs_act ? POL : ~POL), (w_vs_act ? POL : ~POL), w_blank_n};

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign w_out = w_dec;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0][2:0] r_dly;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dly <= {SYNC_DELAY{INACT}};
        end else begin
          r_dly[0] <= w_dec;
          for (int i = 1; i < SYNC_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_out = r_dly[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.pixelX       = r_x;
  assign vga.pixelY       = r_y;
  assign vga.pixelTick    = r_tick;
  assign vga.startOfFrame = r_sof;
  assign vga.hsync        = w_out[2];
  assign vga.vsync        = w_out[1];
  assign vga.blankN       = w_out[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five parameter sets share clk/reset and are compared
// against a tick-count model (position = arithmetic on ticks since reset).
module tb_vga_timing_gen;
  localparam int N = 5;
  // 0: defaults; 1: delay 0; 2: delay 2 active-high; 3/4: tiny raster, delay 0 / 3 active-high
  localparam int HA[N] = '{640, 640, 640, 8, 8};
  localparam int HF[N] = '{16, 16, 16, 2, 2};
  localparam int HS[N] = '{96, 96, 96, 3, 3};
  localparam int HB[N] = '{48, 48, 48, 2, 2};
  localparam int VA[N] = '{480, 480, 480, 4, 4};
  localparam int VF[N] = '{10, 10, 10, 1, 1};
  localparam int VS[N] = '{2, 2, 2, 2, 2};
  localparam int VB[N] = '{33, 33, 33, 1, 1};
  localparam int SP[N] = '{0, 0, 1, 0, 1};
  localparam int DL[N] = '{1, 0, 2, 0, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_if if0 ();
  vga_timing_if if1 ();
  vga_timing_if if2 ();
  vga_timing_if if3 ();
  vga_timing_if if4 ();

  vga_timing_gen #(.SYNC_POL(0), .SYNC_DELAY(1)) u0 (.clk(clk), .reset(reset), .vga(if0));
  vga_timing_gen #(.SYNC_POL(0), .SYNC_DELAY(0)) u1 (.clk(clk), .reset(reset), .vga(if1));
  vga_timing_gen #(.SYNC_POL(1), .SYNC_DELAY(2)) u2 (.clk(clk), .reset(reset), .vga(if2));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .SYNC_DELAY(0))
    u3 (.clk(clk), .reset(reset), .vga(if3));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(1), .SYNC_DELAY(3))
    u4 (.clk(clk), .reset(reset), .vga(if4));

  logic [10:0] ox[N], oy[N];
  logic        otk[N], osf[N];
  logic [2:0]  opin[N];
  assign ox[0] = if0.pixelX; assign oy[0] = if0.pixelY; assign otk[0] = if0.pixelTick;
  assign osf[0] = if0.startOfFrame; assign opin[0] = {if0.hsync, if0.vsync, if0.blankN};
  assign ox[1] = if1.pixelX; assign oy[1] = if1.pixelY; assign otk[1] = if1.pixelTick;
  assign osf[1] = if1.startOfFrame; assign opin[1] = {if1.hsync, if1.vsync, if1.blankN};
  assign ox[2] = if2.pixelX; assign oy[2] = if2.pixelY; assign otk[2] = if2.pixelTick;
  assign osf[2] = if2.startOfFrame; assign opin[2] = {if2.hsync, if2.vsync, if2.blankN};
  assign ox[3] = if3.pixelX; assign oy[3] = if3.pixelY; assign otk[3] = if3.pixelTick;
  assign osf[3] = if3.startOfFrame; assign opin[3] = {if3.hsync, if3.vsync, if3.blankN};
  assign ox[4] = if4.pixelX; assign oy[4] = if4.pixelY; assign otk[4] = if4.pixelTick;
  assign osf[4] = if4.startOfFrame; assign opin[4] = {if4.hsync, if4.vsync, if4.blankN};

  // Reference: m_n = pixel ticks consumed since reset; m_hist[d] = m_n as of d clks ago.
  int m_n, m_edges;
  bit m_tick, m_adv;
  int m_hist[4];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n = 0; m_edges = 0; m_tick = 0; m_adv = 0;
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
    end else begin
      m_adv = m_tick;
      m_n = m_n + (m_tick ? 1 : 0);
      m_edges++;
`ifdef VGA_CLK_DIV2_EN
      m_tick = (m_edges % 2 == 1);
`else
      m_tick = 1'b1;
`endif
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_n;
    end
  end

  function automatic int htot(int i); return HA[i] + HF[i] + HS[i] + HB[i]; endfunction
  function automatic int vtot(int i); return VA[i] + VF[i] + VS[i] + VB[i]; endfunction
  function automatic logic [2:0] idle_pins(int i);
    logic p = (SP[i] != 0);
    return {~p, ~p, 1'b0};
  endfunction

  function automatic logic [2:0] exp_dec(int i, int n);
    int x = n % htot(i);
    int y = (n / htot(i)) % vtot(i);
    logic p = (SP[i] != 0);
    logic hs = (x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]);
    logic vs = (y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]);
    logic bl = (x < HA[i]) && (y < VA[i]);
    return {hs ? p : ~p, vs ? p : ~p, bl};
  endfunction

  function automatic logic [2:0] exp_pins(int i);
    if (reset || m_edges < DL[i]) return idle_pins(i);
    return exp_dec(i, m_hist[DL[i]]);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ox[i] !== 11'd0 || oy[i] !== 11'd0 || otk[i] !== 1'b0 || osf[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d got x=%0d y=%0d tick=%b sof=%b exp 0 0 0 0",
                 i, ox[i], oy[i], otk[i], osf[i]);
      end
      checks++;
      if (opin[i] !== idle_pins(i)) begin
        failures++;
        $display("FAIL reset_pins dut%0d got %b exp %b", i, opin[i], idle_pins(i));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan(int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        int ex = m_n % htot(i);
        int ey = (m_n / htot(i)) % vtot(i);
        logic esof = m_adv && (m_n != 0) && (m_n % (htot(i) * vtot(i)) == 0);
        checks++;
        if (ox[i] !== 11'(ex) || oy[i] !== 11'(ey)) begin
          failures++;
          $display("FAIL scan_xy dut%0d got (%0d,%0d) exp (%0d,%0d)", i, ox[i], oy[i], ex, ey);
        end
        checks++;
        if ({otk[i], osf[i]} !== {m_tick, esof}) begin
          failures++;
          $display("FAIL scan_tick_sof dut%0d got %b%b exp %b%b", i, otk[i], osf[i], m_tick, esof);
        end
        checks++;
        if (opin[i] !== exp_pins(i)) begin
          failures++;
          $display("FAIL scan_pins dut%0d x=%0d got hvb=%b exp %b", i, ox[i], opin[i], exp_pins(i));
        end
      end
    end
  endtask

  // Fixed-constant checks of the delay taps around the hsync/blank edges of line 0.
  task automatic test_delay();
    int guard = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (ox[2] !== 11'd640 && guard < 4000) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 4000) begin failures++; $display("FAIL delay_wait640 timeout got x=%0d exp 640", ox[2]); end
    checks++;
    if (opin[1][0] !== 1'b0) begin failures++; $display("FAIL blank_d0 got %b exp 0", opin[1][0]); end
    @(negedge clk);
    checks++;
    if (opin[2][0] !== 1'b1) begin failures++; $display("FAIL blank_d2_early got %b exp 1", opin[2][0]); end
    @(negedge clk);
    checks++;
    if (opin[2][0] !== 1'b0) begin failures++; $display("FAIL blank_d2 got %b exp 0", opin[2][0]); end
    guard = 0;
    while (ox[2] !== 11'd656 && guard < 4000) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 4000) begin failures++; $display("FAIL delay_wait656 timeout got x=%0d exp 656", ox[2]); end
    checks++;
    if (opin[1][2] !== 1'b0 || opin[2][2] !== 1'b0)
      begin failures++; $display("FAIL hsync_656 got d0=%b d2=%b exp 0 0", opin[1][2], opin[2][2]); end
    @(negedge clk);
    checks++;
    if (opin[2][2] !== 1'b0) begin failures++; $display("FAIL hsync_d2_early got %b exp 0", opin[2][2]); end
    @(negedge clk);
    checks++;
    if (opin[2][2] !== 1'b1) begin failures++; $display("FAIL hsync_d2 got %b exp 1", opin[2][2]); end
  endtask

  task automatic test_frame_wrap();
    int guard = 0;
    while (osf[3] !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 2000) begin
      failures++;
      $display("FAIL sof_wait timeout got sof=%b exp 1", osf[3]);
    end else begin
      checks++;
      if (ox[3] !== 11'd0 || oy[3] !== 11'd0) begin
        failures++;
        $display("FAIL sof_pos got (%0d,%0d) exp (0,0)", ox[3], oy[3]);
      end
      @(negedge clk);
      checks++;
      if (osf[3] !== 1'b0) begin failures++; $display("FAIL sof_width got %b exp 0", osf[3]); end
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(50, 900)) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ox[i] !== 11'd0 || oy[i] !== 11'd0 || otk[i] !== 1'b0 || osf[i] !== 1'b0 ||
            opin[i] !== idle_pins(i)) begin
          failures++;
          $display("FAIL mid_reset dut%0d got x=%0d y=%0d t=%b s=%b hvb=%b exp 0 0 0 0 %b",
                   i, ox[i], oy[i], otk[i], osf[i], opin[i], idle_pins(i));
        end
      end
      @(negedge clk);
      reset = 1'b0;
      test_scan($urandom_range(100, 400));
    end
  endtask

  initial begin
    test_reset();
    test_scan(1800);
    test_frame_wrap();
    test_delay();
    test_mid_reset();
    test_scan(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan for the VGA output path: pixel counters `pixelX`/`pixelY` that drive every draw stage (borders, sprites, background) plus `hsync`, `vsync` and `blankN` for the DAC/connector. The sync and blank outputs pass through a configurable delay line, so they stay aligned with the registered RGB produced one or more clocks later by the draw/mux stages. Sits at the head of the video pipeline, directly upstream of all `*_draw` blocks.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync polarity: 0 = active-low, 1 = active-high
- `SYNC_DELAY`, 1, clocks of delay applied to `hsync`/`vsync`/`blankN` relative to `pixelX`/`pixelY`; legal range 0..3

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `pixelX` out 11: current horizontal position, 0..H_TOTAL-1
- `pixelY` out 11: current vertical position, 0..V_TOTAL-1
- `pixelTick` out 1: one-clk pulse; the counters advance on the next edge
- `startOfFrame` out 1: one-clk pulse on the first clk at which the counters hold (0,0) after a wrap
- `hsync` out 1: horizontal sync, polarity per `SYNC_POL`, delayed `SYNC_DELAY` clks
- `vsync` out 1: vertical sync, polarity per `SYNC_POL`, delayed `SYNC_DELAY` clks
- `blankN` out 1: 1 inside the active area, delayed `SYNC_DELAY` clks

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- On `pixelTick`:
  - `pixelX` increments.
  - When `pixelX` = H_TOTAL-1, it wraps to 0 and `pixelY` increments.
  - When `pixelY` = V_TOTAL-1 and `pixelX` = H_TOTAL-1, both wrap to 0.
- Undelayed decode, valid in the same clk as the counter values:
  - hsync active when H_ACTIVE+H_FP ≤ X < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active when V_ACTIVE+V_FP ≤ Y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blankN = (X < H_ACTIVE) && (Y < V_ACTIVE).
- Output polarity: an active sync drives `SYNC_POL`; an inactive sync drives `~SYNC_POL`.
- Delay line: the decoded hsync/vsync/blankN pass through `SYNC_DELAY` flop stages clocked every `clk`, not gated by `pixelTick`. With `SYNC_DELAY`=0 the outputs are the decode taken directly from the registered counters.
- `startOfFrame` is registered. It is high for exactly one clk: the first clk at which the counters equal (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1).
- Arithmetic: counters are 11 bits unsigned. All comparisons are unsigned against parameter-derived constants. No overflow is possible for legal parameters (totals ≤ 2047).

## Timing
- Reset values:
  - `pixelX`=0, `pixelY`=0.
  - `pixelTick`=0, `startOfFrame`=0.
  - `hsync`=`vsync`=`~SYNC_POL`, `blankN`=0.
  - All delay stages are loaded with the inactive values (sync inactive, blankN=0).
- After reset deasserts, the counters start at (0,0). The first frame produces no `startOfFrame`; the first pulse comes at the first wrap.
- Reset asserted mid-frame: all state clears asynchronously within the same cycle. There is no partial-line recovery.
- Counter-to-output latency: sync/blank at the pins reflect the counter value from `SYNC_DELAY` clks earlier. Draw stages with one register stage use `SYNC_DELAY`=1.
- `pixelTick` cadence: every clk without the divider macro; every second clk with it (see Configuration).

## Configuration
- `VGA_CLK_DIV2_EN`:
  - Defined: an internal toggle flop divides `clk` by 2. `pixelTick` is high on alternate clks, starting on the 2nd clk after reset deassert. Counters hold on non-tick clks.
  - Undefined: `pixelTick` is tied to 1 after reset (low during reset), and counters advance every clk.
  - In both cases the delay line counts `clk` edges, not pixels.

## Test plan
- Reset, then release with the macro undefined and default params → `pixelX` 0,1,2,…; after 800 clks `pixelX`=0 and `pixelY`=1; after 420000 clks `startOfFrame`=1 for exactly one clk with the counters at (0,0).
- Horizontal decode, `SYNC_DELAY`=0 → `hsync`=0 exactly while `pixelX` ∈ 656..751, and `blankN`=0 from `pixelX`=640 on line 0.
- Vertical decode → `vsync`=0 only for lines 490 and 491; `blankN`=0 for all of lines 480..524.
- `SYNC_DELAY`=2 → `hsync` falls 2 clks after the `pixelX`=656 clk; `blankN` falls 2 clks after the `pixelX`=640 clk.
- `VGA_CLK_DIV2_EN` defined → each `pixelX` value is held for 2 clks; one line is 1600 clks; `pixelTick` duty cycle is 50%.
- Assert `reset` at `pixelX`=300, `pixelY`=200, with `SYNC_POL`=1 → all outputs go immediately to their reset values (`hsync`=`vsync`=0, `blankN`=0); after release, counting restarts from (0,0).
